// File: rtl/apb_spi_regif.sv
// apb_spi_regif
//   APB3 slave front end for the SPI master register port. An APB setup
//   phase is turned into a single one-cycle WR/DR strobe toward the master,
//   write data is forwarded on o_WDATA, read data is captured into PRDATA,
//   and the access phase is stretched with wait states until PREADY.
//   TX/CMD writes wait for the master to go idle, bounded by TIMEOUT cycles
//   (0 = wait forever).
// Ports
//   PCLK, PRESET        clock, synchronous active-high reset
//   PSEL .. PWDATA      APB3 request
//   PRDATA, PREADY,     APB3 response; PREADY is a one-cycle pulse and
//   PSLVERR             PSLVERR is only meaningful with it
//   o_WR, o_DR          one-hot, one-cycle strobes to the master
//   o_WDATA             write data to the master, held until the next write
//   i_RDATA             master read data, valid the cycle after a DR strobe
//   i_BUSY              master transfer in progress
module apb_spi_regif #(
   parameter int TIMEOUT = 16
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [3:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR,
   output logic [3:0] o_WR,
   output logic [3:0] o_DR,
   output logic [7:0] o_WDATA,
   input  logic [7:0] i_RDATA,
   input  logic       i_BUSY
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = (TIMEOUT == 0) ? {CW{1'b1}} : CW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BUSY,
      STROBE,
      CAPTURE,
      DONE
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    addr_q;
   logic          write_q;
   logic [7:0]    wdata_q;
   logic          err_q, err_nxt;
   logic [CW-1:0] cnt, cnt_inc;
   logic          setup;
   logic [3:0]    sel_addr;
   logic          sel_wr;
   logic [7:0]    sel_wdata;
   logic [3:0]    strobe_bits;
   logic [3:0]    wr_nxt, dr_nxt;
   logic          wdata_ld;

   // saturating busy-wait counter
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      setup     = 1'b0;
      case (state)
         IDLE: begin
            // an access phase without a preceding setup is ignored
            if (PSEL && !PENABLE) begin
               setup   = 1'b1;
               err_nxt = 1'b0;
               if (|PADDR[3:2]) begin
                  state_nxt = DONE;
                  err_nxt   = 1'b1;
               end else if (PWRITE && PADDR[0] && i_BUSY) begin
                  state_nxt = WAIT_BUSY;
               end else begin
                  state_nxt = STROBE;
               end
            end
         end
         WAIT_BUSY: begin
            // master going idle wins over a simultaneous timeout
            if (!i_BUSY) begin
               state_nxt = STROBE;
            end else if (TIMEOUT != 0 && cnt_inc == CNT_MAX) begin
               state_nxt = DONE;
               err_nxt   = 1'b1;
            end
         end
         STROBE:  state_nxt = write_q ? DONE : CAPTURE;
         CAPTURE: state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // deselect aborts the transfer; no response is given
      if (state != IDLE && !PSEL) state_nxt = IDLE;
   end

   // strobes are registered on entry to STROBE so they are clean one-cycle
   // pulses; from IDLE the request fields are not latched yet, so take them
   // straight from the bus
   always_comb begin
      sel_addr    = setup ? PADDR  : addr_q;
      sel_wr      = setup ? PWRITE : write_q;
      sel_wdata   = setup ? PWDATA : wdata_q;
      strobe_bits = 4'd1 << sel_addr[1:0];
      wr_nxt      = 4'd0;
      dr_nxt      = 4'd0;
      wdata_ld    = 1'b0;
      if (state_nxt == STROBE) begin
         if (sel_wr) begin
            wr_nxt   = strobe_bits;
            wdata_ld = 1'b1;
         end else begin
            dr_nxt   = strobe_bits;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state   <= IDLE;
         addr_q  <= 4'd0;
         write_q <= 1'b0;
         wdata_q <= 8'd0;
         err_q   <= 1'b0;
         cnt     <= '0;
         PRDATA  <= 8'd0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         o_WR    <= 4'd0;
         o_DR    <= 4'd0;
         o_WDATA <= 8'd0;
      end else begin
         state   <= state_nxt;
         err_q   <= err_nxt;
         if (setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            cnt     <= '0;
         end else if (state == WAIT_BUSY) begin
            cnt     <= cnt_inc;
         end
         o_WR    <= wr_nxt;
         o_DR    <= dr_nxt;
         if (wdata_ld) o_WDATA <= sel_wdata;
         // only a completed read updates PRDATA
         if (state == CAPTURE && state_nxt == DONE) PRDATA <= i_RDATA;
         PREADY  <= (state_nxt == DONE);
         PSLVERR <= (state_nxt == DONE) && err_nxt;
      end
   end

endmodule
